rop_dcr_ctrl: RTL and testbench

- Owns the ROP unit's configuration register set (the rop_dcrs_t fields) and sequences configuration changes against in-flight ROP traffic.
- DCR writes land in a shadow copy. A commit handshake drains the ROP pipeline, then swaps shadow into active in one cycle.
- Sits between the DCR bus and the ROP unit's request gate. The active set is what the ROP datapath consumes.

---
 rtl/rop_dcr_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rop_dcr_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rop_dcr_ctrl.sv
// rop_dcr_ctrl: ROP configuration register set with shadow/active copies and drain-then-swap commit.
// Ports: clk/reset_n (async active-low); dcr_wr_* shadow write port; commit_valid/commit_ready
// commit handshake; rop_req_fire/rop_rsp_fire in-flight tracking; rop_req_enable request gate;
// dcrs active config (rop_dcrs_t packing); config_epoch swap counter; busy during DRAIN/SWAP.
// Optional ROP_DCR_READBACK_EN adds dcr_rd_addr/dcr_rd_sel/dcr_rd_data (registered readback).
package rop_dcr_pkg;
  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] ref_val;
    logic [2:0] fail;
    logic [2:0] zfail;
    logic [2:0] zpass;
    logic [2:0] func;
  } rop_stencil_t;
  typedef struct packed {
    logic [31:0]  cbuf_addr;
    logic [31:0]  cbuf_pitch;
    logic [31:0]  cbuf_mask;
    logic [31:0]  zbuf_addr;
    logic [31:0]  zbuf_pitch;
    logic         depth_writemask;
    logic [2:0]   depth_func;
    rop_stencil_t stencil_front;
    rop_stencil_t stencil_back;
    logic [7:0]   stencil_writemask;
    logic [2:0]   blend_mode_a;
    logic [2:0]   blend_mode_rgb;
    logic [3:0]   blend_dst_a;
    logic [3:0]   blend_dst_rgb;
    logic [3:0]   blend_src_a;
    logic [3:0]   blend_src_rgb;
    logic [31:0]  blend_const;
    logic [3:0]   logic_op;
  } rop_dcrs_t;
endpackage

module rop_dcr_ctrl
  import rop_dcr_pkg::*;
#(
  parameter int MAX_INFLIGHT  = 16,
  parameter int DCR_ADDR_BITS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          dcr_wr_valid,
  input  logic [DCR_ADDR_BITS-1:0]      dcr_wr_addr,
  input  logic [31:0]                   dcr_wr_data,
  input  logic                          commit_valid,
  output logic                          commit_ready,
  input  logic                          rop_req_fire,
  input  logic                          rop_rsp_fire,
  output logic                          rop_req_enable,
  output logic [$bits(rop_dcrs_t)-1:0]  dcrs,
  output logic [7:0]                    config_epoch,
`ifdef ROP_DCR_READBACK_EN
  input  logic [DCR_ADDR_BITS-1:0]      dcr_rd_addr,
  input  logic                          dcr_rd_sel,
  output logic [31:0]                   dcr_rd_data,
`endif
  output logic                          busy
);
  localparam int CNT_BITS = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

  state_t              state_q, state_d;
  rop_dcrs_t           shadow_q, shadow_d, active_q, active_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]          epoch_q, epoch_d;
  logic                commit_ready_q, commit_ready_d, busy_q, busy_d;

  always_comb begin
    shadow_d = shadow_q;
    if (dcr_wr_valid)
      case (int'(dcr_wr_addr))
        0:  shadow_d.cbuf_addr = dcr_wr_data;
        1:  shadow_d.cbuf_pitch = dcr_wr_data;
        2:  shadow_d.cbuf_mask = dcr_wr_data;
        3:  shadow_d.zbuf_addr = dcr_wr_data;
        4:  shadow_d.zbuf_pitch = dcr_wr_data;
        5:  {shadow_d.depth_writemask, shadow_d.depth_func} = dcr_wr_data[3:0];
        6:  shadow_d.stencil_front = dcr_wr_data[27:0];
        7:  shadow_d.stencil_back = dcr_wr_data[27:0];
        8:  shadow_d.stencil_writemask = dcr_wr_data[7:0];
        9:  {shadow_d.blend_mode_a, shadow_d.blend_mode_rgb} = dcr_wr_data[5:0];
        10: {shadow_d.blend_dst_a, shadow_d.blend_dst_rgb,
             shadow_d.blend_src_a, shadow_d.blend_src_rgb} = dcr_wr_data[15:0];
        11: shadow_d.blend_const = dcr_wr_data;
        12: shadow_d.logic_op = dcr_wr_data[3:0];
        default: ;
      endcase
    // A stray response at zero holds the counter rather than wrapping it.
    cnt_d = (rop_req_fire && !rop_rsp_fire) ? cnt_q + 1'b1 :
            (rop_rsp_fire && !rop_req_fire && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    state_d = (state_q == IDLE)  ? (commit_valid ? DRAIN : IDLE) :
              (state_q == DRAIN) ? ((cnt_q == '0) ? SWAP : DRAIN) : IDLE;
    active_d = (state_q == SWAP) ? shadow_q : active_q;
    epoch_d = (state_q == SWAP) ? epoch_q + 8'd1 : epoch_q;
    commit_ready_d = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q        <= IDLE;
      shadow_q       <= '0;
      active_q       <= '0;
      cnt_q          <= '0;
      epoch_q        <= '0;
      commit_ready_q <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      cnt_q          <= cnt_d;
      epoch_q        <= epoch_d;
      commit_ready_q <= commit_ready_d;
      busy_q         <= busy_d;
    end

  assign rop_req_enable = (state_q == IDLE) && (cnt_q < CNT_MAX);
  assign commit_ready   = commit_ready_q;
  assign busy           = busy_q;
  assign dcrs           = active_q;
  assign config_epoch   = epoch_q;

`ifdef ROP_DCR_READBACK_EN
  function automatic logic [31:0] pack_word(rop_dcrs_t d, logic [DCR_ADDR_BITS-1:0] a);
    case (int'(a))
      0:  return d.cbuf_addr;
      1:  return d.cbuf_pitch;
      2:  return d.cbuf_mask;
      3:  return d.zbuf_addr;
      4:  return d.zbuf_pitch;
      5:  return {28'd0, d.depth_writemask, d.depth_func};
      6:  return {4'd0, d.stencil_front};
      7:  return {4'd0, d.stencil_back};
      8:  return {24'd0, d.stencil_writemask};
      9:  return {26'd0, d.blend_mode_a, d.blend_mode_rgb};
      10: return {16'd0, d.blend_dst_a, d.blend_dst_rgb, d.blend_src_a, d.blend_src_rgb};
      11: return d.blend_const;
      12: return {28'd0, d.logic_op};
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] rd_data_q, rd_data_d;

  always_comb rd_data_d = pack_word(dcr_rd_sel ? active_q : shadow_q, dcr_rd_addr);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;

  assign dcr_rd_data = rd_data_q;
`endif

  a_rsp_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(rop_rsp_fire && !rop_req_fire && cnt_q == '0));
  a_req_gated: assert property (@(posedge clk) disable iff (!reset_n)
    !(rop_req_fire && !rop_req_enable));
endmodule

// File: tb/tb_rop_dcr_ctrl.sv
// tb_rop_dcr_ctrl: directed and random stimulus against a word-level model of the DCR controller.
module tb_rop_dcr_ctrl;
  import rop_dcr_pkg::*;

  logic        clk = 0, reset_n = 0;
  logic        dcr_wr_valid = 0;
  logic [3:0]  dcr_wr_addr = 0;
  logic [31:0] dcr_wr_data = 0;
  logic        commit_valid = 0, rop_req_fire = 0, rop_rsp_fire = 0;
  logic        commit_ready, rop_req_enable, busy;
  logic [$bits(rop_dcrs_t)-1:0] dcrs;
  logic [7:0]  config_epoch;
`ifdef ROP_DCR_READBACK_EN
  logic [3:0]  dcr_rd_addr = 0;
  logic        dcr_rd_sel = 0;
  logic [31:0] dcr_rd_data;
`endif

  rop_dcr_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .rop_req_fire(rop_req_fire), .rop_rsp_fire(rop_rsp_fire), .rop_req_enable(rop_req_enable),
    .dcrs(dcrs), .config_epoch(config_epoch),
`ifdef ROP_DCR_READBACK_EN
    .dcr_rd_addr(dcr_rd_addr), .dcr_rd_sel(dcr_rd_sel), .dcr_rd_data(dcr_rd_data),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(int i);
    case (i)
      5, 12:  return 32'h0000_000F;
      6, 7:   return 32'h0FFF_FFFF;
      8:      return 32'h0000_00FF;
      9:      return 32'h0000_003F;
      10:     return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] get_word(rop_dcrs_t d, int i);
    case (i)
      0:  return d.cbuf_addr;
      1:  return d.cbuf_pitch;
      2:  return d.cbuf_mask;
      3:  return d.zbuf_addr;
      4:  return d.zbuf_pitch;
      5:  return {28'd0, d.depth_writemask, d.depth_func};
      6:  return {4'd0, d.stencil_front};
      7:  return {4'd0, d.stencil_back};
      8:  return {24'd0, d.stencil_writemask};
      9:  return {26'd0, d.blend_mode_a, d.blend_mode_rgb};
      10: return {16'd0, d.blend_dst_a, d.blend_dst_rgb, d.blend_src_a, d.blend_src_rgb};
      11: return d.blend_const;
      default: return {28'd0, d.logic_op};
    endcase
  endfunction

  // Model: per-word shadow/active images, outstanding count, and commit progress flags.
  logic [31:0] m_sh[13], m_act[13];
  logic [7:0]  m_ep = 0;
  int          mc = 0;
  bit          m_pend = 0, m_swap = 0;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < 13; k++) begin m_sh[k] = 0; m_act[k] = 0; end
      m_ep = 0; mc = 0; m_pend = 0; m_swap = 0;
    end else begin
      if (m_swap) begin
        for (int k = 0; k < 13; k++) m_act[k] = m_sh[k];
        m_ep = m_ep + 8'd1;
        m_swap = 0;
      end else if (m_pend) begin
        if (mc == 0) begin m_swap = 1; m_pend = 0; end
      end else if (commit_valid) m_pend = 1;
      if (dcr_wr_valid && dcr_wr_addr < 13) m_sh[dcr_wr_addr] = dcr_wr_data & wmask(int'(dcr_wr_addr));
      if (rop_req_fire && !rop_rsp_fire) mc++;
      else if (rop_rsp_fire && !rop_req_fire && mc > 0) mc--;
    end

  always @(negedge clk)
    if (reset_n) begin
      chk("epoch", {24'd0, config_epoch}, {24'd0, m_ep});
      chk("commit_ready", {31'd0, commit_ready}, {31'd0, !(m_pend || m_swap)});
      chk("busy", {31'd0, busy}, {31'd0, m_pend || m_swap});
      chk("req_enable", {31'd0, rop_req_enable}, {31'd0, !(m_pend || m_swap) && mc < 16});
      for (int i = 0; i < 13; i++) chk($sformatf("dcr_word%0d", i), get_word(rop_dcrs_t'(dcrs), i), m_act[i]);
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    dcr_wr_valid = 1; dcr_wr_addr = a; dcr_wr_data = d;
    cyc(1);
    dcr_wr_valid = 0;
  endtask

  task automatic commit();
    commit_valid = 1;
    cyc(1);
    commit_valid = 0;
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_dcrs"}, {31'd0, |dcrs}, 32'd0);
    chk({n, "_epoch"}, {24'd0, config_epoch}, 32'd0);
    chk({n, "_ready"}, {31'd0, commit_ready}, 32'd1);
    chk({n, "_enable"}, {31'd0, rop_req_enable}, 32'd1);
    chk({n, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    cyc(2);
    chk_reset_vals("reset");
    reset_n = 1;
    cyc(1);
    // shadow write is invisible until committed
    wr(4'd0, 32'h8000_0000);
    cyc(10);
    chk("nocommit_cbuf", get_word(rop_dcrs_t'(dcrs), 0), 32'd0);
    commit();
    cyc(1);
    chk("swap_cycle_cbuf", get_word(rop_dcrs_t'(dcrs), 0), 32'd0);
    cyc(1);
    chk("t3_cbuf", get_word(rop_dcrs_t'(dcrs), 0), 32'h8000_0000);
    chk("t3_epoch", {24'd0, config_epoch}, 32'd1);
    // drain with three outstanding requests
    rop_req_fire = 1; cyc(3); rop_req_fire = 0;
    commit();
    for (int k = 0; k < 3; k++) begin
      chk("drain_busy", {31'd0, busy}, 32'd1);
      chk("drain_enable", {31'd0, rop_req_enable}, 32'd0);
      rop_rsp_fire = 1; cyc(1); rop_rsp_fire = 0;
      chk("drain_busy2", {31'd0, busy}, 32'd1);
      cyc(1);
    end
    chk("swap_busy", {31'd0, busy}, 32'd1);
    chk("swap_enable", {31'd0, rop_req_enable}, 32'd0);
    cyc(1);
    chk("post_swap_enable", {31'd0, rop_req_enable}, 32'd1);
    chk("post_swap_epoch", {24'd0, config_epoch}, 32'd2);
    // in-flight limit
    rop_req_fire = 1; cyc(16); rop_req_fire = 0;
    chk("full_enable", {31'd0, rop_req_enable}, 32'd0);
    rop_rsp_fire = 1; cyc(1); rop_rsp_fire = 0;
    chk("full_minus1_enable", {31'd0, rop_req_enable}, 32'd1);
    rop_rsp_fire = 1; cyc(15); rop_rsp_fire = 0;
    // write during DRAIN joins the swap; write in SWAP waits for next commit
    rop_req_fire = 1; cyc(1); rop_req_fire = 0;
    commit();
    dcr_wr_valid = 1; dcr_wr_addr = 4'd6; dcr_wr_data = 32'h0000_FFAB; rop_rsp_fire = 1;
    cyc(1);
    dcr_wr_valid = 0; rop_rsp_fire = 0;
    cyc(1);
    chk("stencil_swap_busy", {31'd0, busy}, 32'd1);
    wr(4'd6, 32'h1);
    chk("stencil_drain_write", get_word(rop_dcrs_t'(dcrs), 6), 32'h0000_FFAB);
    commit(); cyc(2);
    chk("stencil_second_commit", get_word(rop_dcrs_t'(dcrs), 6), 32'h1);
    chk("stencil_epoch", {24'd0, config_epoch}, 32'd4);
    // asynchronous reset mid-DRAIN
    wr(4'd2, 32'hFFFF_FFFF);
    rop_req_fire = 1; cyc(1); rop_req_fire = 0;
    commit();
    cyc(1);
    #2 reset_n = 0;
    #1 chk_reset_vals("midrst");
    chk("midrst_cbuf_mask", get_word(rop_dcrs_t'(dcrs), 2), 32'd0);
    @(negedge clk) reset_n = 1;
    cyc(1);
    // epoch wrap
    for (int k = 0; k < 255; k++) begin commit(); cyc(2); end
    chk("epoch_255", {24'd0, config_epoch}, 32'd255);
    commit(); cyc(2);
    chk("epoch_wrap", {24'd0, config_epoch}, 32'd0);
    // simultaneous req and rsp leave the count alone
    rop_req_fire = 1; cyc(15);
    rop_rsp_fire = 1; cyc(3); rop_rsp_fire = 0;
    chk("both_fire_enable", {31'd0, rop_req_enable}, 32'd1);
    cyc(1); rop_req_fire = 0;
    chk("both_fire_full", {31'd0, rop_req_enable}, 32'd0);
    rop_rsp_fire = 1; cyc(16); rop_rsp_fire = 0;
    // randomized traffic
    repeat (3000) begin
      dcr_wr_valid = ($urandom % 3) == 0;
      dcr_wr_addr  = 4'($urandom % 16);
      dcr_wr_data  = $urandom;
      commit_valid = ($urandom % 8) == 0;
      rop_req_fire = rop_req_enable && mc < 16 && ($urandom % 2) == 1;
      rop_rsp_fire = mc > 0 && ($urandom % 3) == 0;
      cyc(1);
    end
    dcr_wr_valid = 0; commit_valid = 0; rop_req_fire = 0; rop_rsp_fire = 0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
